pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central stall/flush/redirect controller for the five-stage in-order pipeline (IF, ID, EX, MEM, WB). It gathers per-stage stall requests, the EX-stage branch resolution and the MEM-stage exception, and drives a hold/bubble vector to the PC register and the four pipeline registers (if_id, id_ex, ex_mem, mem_wb). A redirect that the fetch unit cannot accept immediately (IF stalled on a miss) is held pending until fetch is free.

## Interface
- ADDR_W, 32, PC/target width (matches instruction-address width)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_stall_req  in  1  IF busy (icache miss)
- id_stall_req  in  1  ID load-use / operand not ready
- ex_stall_req  in  1  EX multi-cycle op busy
- mem_stall_req  in  1  MEM busy (dcache miss)
- br_taken  in  1  EX resolved taken branch / mispredict
- br_target  in  ADDR_W  branch redirect address
- excp_valid  in  1  MEM-stage exception or ertn
- excp_target  in  ADDR_W  handler entry / return address
- stall  out  5  hold enables: [0]=pc, [1]=if_id, [2]=id_ex, [3]=ex_mem, [4]=mem_wb
- flush  out  5  bubble-load enables, same indexing ([0] unused, always 0)
- redirect_valid  out  1  fetch must restart at redirect_pc
- redirect_pc  out  ADDR_W  restart address
- stall_cycles  out  32  count of cycles with stall[0]=1

## Operation
- Stage indices: IF=0, ID=1, EX=2, MEM=3. d = deepest requesting stage (priority MEM>EX>ID>IF); no request -> none.
- Stall rule: stall[j]=1 for all j<=d; flush[d+1]=1 (bubble into the register below the stalled stage). d=3 -> stall[3:0]=1, flush[4]=1.
- Branch: accepted only when d<2 (EX not held) and no exception. Accepted -> flush[1]=flush[2]=1, overriding stall on those indices; stall[0]=0.
- Exception: highest priority, overrides all stall requests and any branch: stall=0, flush[4:1]=4'b1111.
- Redirect issue: on acceptance, if if_stall_req=0 -> redirect_valid=1, redirect_pc=target for that cycle only (combinational path from inputs); else latch target, enter PEND.
- FSM states: RUN, PEND.
  - RUN -> PEND: accepted redirect with if_stall_req=1.
  - PEND: redirect_valid=1, redirect_pc=latched target, flush[1]=1 each cycle (wrong-path fetch squashed), stall[0]=0.
  - PEND -> RUN: if_stall_req=0 (redirect consumed that cycle).
  - Exception in PEND: replaces latched target; stays in PEND if if_stall_req=1, else RUN.
  - Branch in PEND: ignored unless d<2, then it replaces latched target (younger-first wins only if older not yet redirected; since EX is older than pending path, accept).
- stall_cycles: increments by 1 (wraps at 2^32) each cycle stall[0]=1.

## Timing
- stall, flush, and issue-cycle redirect are combinational from inputs and state; no added latency.
- redirect_pc/redirect_valid held from the latch register while in PEND.
- Reset: state=RUN, latched target=0, stall_cycles=0; with all inputs low, stall=0, flush=0, redirect_valid=0, redirect_pc=0.
- Reset mid-PEND: pending redirect discarded, state RUN on the next cycle.
- Simultaneous excp_valid and br_taken: exception wins; branch dropped (its instruction is flushed).

## Structure
- Shared package/define file: stage index constants (STG_IF..STG_MEM), stall/flush vector width (5), state encoding for RUN/PEND.
- Single module; no sub-module required (the stall-priority encoder stays inline).

## Test plan
- id_stall_req=1 alone -> stall=5'b00011, flush=5'b00100, redirect_valid=0; stall_cycles +1 per cycle.
- mem_stall_req=1 with id_stall_req=1 -> stall=5'b01111, flush=5'b10000.
- br_taken=1, br_target=32'h1c00_0100, no stalls -> flush=5'b00110, redirect_valid=1 for one cycle, redirect_pc=32'h1c00_0100.
- br_taken with if_stall_req=1 for 3 cycles -> PEND; redirect_valid=1 and flush[1]=1 each of those cycles; returns to RUN in the cycle if_stall_req drops.
- excp_valid with br_taken and ex_stall_req same cycle, excp_target=32'h1c00_8000 -> stall=0, flush=5'b11110, redirect_pc=32'h1c00_8000.
- rst asserted while in PEND -> next cycle redirect_valid=0, stall_cycles=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stage indices, hold/bubble vector width and state encoding
// shared by the pipeline stall/flush/redirect controller.
package pipe_ctrl_pkg;
   localparam int NSTG = 5;
   localparam logic [1:0] STG_IF  = 2'd0;
   localparam logic [1:0] STG_ID  = 2'd1;
   localparam logic [1:0] STG_EX  = 2'd2;
   localparam logic [1:0] STG_MEM = 2'd3;
   typedef enum logic {RUN, PEND} state_t;
endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/redirect controller for the five-stage pipeline;
// holds a redirect pending while fetch is busy on a miss.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_stall_req,
   input  logic              id_stall_req,
   input  logic              ex_stall_req,
   input  logic              mem_stall_req,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              excp_valid,
   input  logic [ADDR_W-1:0] excp_target,
   output logic [NSTG-1:0]   stall,
   output logic [NSTG-1:0]   flush,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic [31:0]       stall_cycles
);
   state_t            state;
   logic [ADDR_W-1:0] lat;
   logic              has_d, br_ok, acc, pend;
   logic [1:0]        d;
   logic [NSTG-1:0]   stall_b, flush_b;
   logic [ADDR_W-1:0] tgt;
   always_comb begin
      has_d   = mem_stall_req | ex_stall_req | id_stall_req | if_stall_req;
      d       = mem_stall_req ? STG_MEM : ex_stall_req ? STG_EX : id_stall_req ? STG_ID : STG_IF;
      stall_b = has_d ? (NSTG'(2) << d) - NSTG'(1) : '0;
      flush_b = has_d ? NSTG'(2) << d : '0;
      pend    = state == PEND;
      br_ok   = br_taken & ~excp_valid & ~mem_stall_req & ~ex_stall_req;
      acc     = excp_valid | br_ok;
      tgt     = excp_valid ? excp_target : br_target;
   end
   // while a redirect is pending the if_id contents are wrong-path, so squash rather than hold
   always_comb begin
      stall = stall_b;
      flush = flush_b;
      if (pend) begin
         stall[1:0] = 2'b00;
         flush[1]   = 1'b1;
      end
      if (br_ok) begin
         stall[2:0] = 3'b000;
         flush[2:1] = 2'b11;
      end
      if (excp_valid) begin
         stall = '0;
         flush = NSTG'(5'b11110);
      end
      redirect_valid = acc | pend;
      redirect_pc    = acc ? tgt : pend ? lat : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         lat          <= '0;
         stall_cycles <= '0;
      end else begin
         if (stall[0]) stall_cycles <= stall_cycles + 32'd1;
         if (acc) begin
            lat   <= tgt;
            state <= if_stall_req ? PEND : RUN;
         end else if (pend && !if_stall_req) begin
            state <= RUN;
         end
      end
   end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random stimulus against a behavioural model of
// the stall/flush/redirect rules.
module tb_pipe_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        if_stall_req, id_stall_req, ex_stall_req, mem_stall_req;
   logic        br_taken, excp_valid;
   logic [31:0] br_target, excp_target;
   logic [4:0]  stall, flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc, stall_cycles;
   int          n_vec = 0, n_bad = 0;
   logic        m_pend;
   logic [31:0] m_lat, m_cnt;

   pipe_ctrl #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
      .ex_stall_req(ex_stall_req), .mem_stall_req(mem_stall_req),
      .br_taken(br_taken), .br_target(br_target),
      .excp_valid(excp_valid), .excp_target(excp_target),
      .stall(stall), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs, check against the model mid-cycle, then advance the model.
   task automatic cyc(input logic r, input logic i_s, input logic id_s, input logic ex_s,
                      input logic mem_s, input logic br, input logic [31:0] bt,
                      input logic ex, input logic [31:0] et);
      logic [3:0]  req;
      logic [4:0]  es, ef;
      logic [31:0] epc;
      logic        br_ok, erv;
      int          dd;
      rst = r; if_stall_req = i_s; id_stall_req = id_s; ex_stall_req = ex_s;
      mem_stall_req = mem_s; br_taken = br; br_target = bt; excp_valid = ex; excp_target = et;
      req = {mem_s, ex_s, id_s, i_s};
      dd = -1;
      for (int s = 0; s < 4; s++) if (req[s]) dd = s;
      es = '0;
      ef = '0;
      for (int j = 0; j < 5; j++) begin
         if (j <= dd) es[j] = 1'b1;
         if (dd >= 0 && j == dd + 1) ef[j] = 1'b1;
      end
      br_ok = br && !ex && dd < 2;
      if (m_pend) begin
         es[0] = 1'b0; es[1] = 1'b0; ef[1] = 1'b1;
      end
      if (br_ok) begin
         es[2:0] = 3'b000; ef[2:1] = 2'b11;
      end
      if (ex) begin
         es = 5'b00000; ef = 5'b11110;
      end
      erv = ex || br_ok || m_pend;
      epc = ex ? et : br_ok ? bt : m_pend ? m_lat : 32'h0;
      @(negedge clk);
      if (!r) begin
         chk("stall", {27'h0, stall}, {27'h0, es});
         chk("flush", {27'h0, flush}, {27'h0, ef});
         chk("redirect_valid", {31'h0, redirect_valid}, {31'h0, erv});
         chk("redirect_pc", redirect_pc, epc);
         chk("stall_cycles", stall_cycles, m_cnt);
      end
      @(posedge clk);
      if (r) begin
         m_pend = 1'b0; m_lat = 32'h0; m_cnt = 32'h0;
      end else begin
         if (es[0]) m_cnt++;
         if (ex || br_ok) begin
            m_lat  = ex ? et : bt;
            m_pend = i_s;
         end else if (m_pend && !i_s) begin
            m_pend = 1'b0;
         end
      end
      #1;
   endtask

   initial begin
      m_pend = 1'b0; m_lat = 32'h0; m_cnt = 32'h0;
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 32'h1c00_0100, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 1, 32'h1c00_0200, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 1, 32'h1c00_0300, 1, 32'h1c00_8000);
      cyc(0, 1, 0, 0, 0, 1, 32'h1c00_0400, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_pend_cnt", stall_cycles, 32'h0);
      for (int n = 0; n < 3000; n++)
         cyc($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0,
             $urandom, $urandom_range(0, 9) == 0, $urandom);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
